// File: rtl/snn_sorter_pkg.sv
// snn_sorter_pkg: shared state encoding and width helpers for the image sorter
package snn_sorter_pkg;

    typedef enum logic [2:0] {IDLE, SCAN, WAIT_BUSY, WAIT_FREE, EOI, DONE} sorter_state_t;

    function automatic int idx_width(input int image_size_bits);
        return image_size_bits + 1;
    endfunction

    function automatic int pix_width(input int pixel_bits);
        return pixel_bits + 1;
    endfunction

    // The end-of-image token is the first index past the last pixel
    function automatic int end_token(input int image_size);
        return image_size;
    endfunction

endpackage

// File: rtl/image_sorter.sv
// image_sorter: emits pixel indices in descending value order over an AER handshake
//   CLK, RST                : clock, async active-high reset
//   IMG_WR_EN/ADDR/DATA     : pixel load port, accepted only while idle
//   START                   : begins one sort pass
//   AERIN_CTRL_BUSY         : downstream stage busy, handshakes every emission
//   NEXT_INDEX, FOUND_NEXT_INDEX : emitted index (or end token) and its one-cycle valid
//   SORTER_BUSY, SORT_DONE  : pass in progress, one-cycle pass completion pulse
module image_sorter
    import snn_sorter_pkg::*;
#(
    parameter int IMAGE_SIZE      = 5,
    parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
    parameter int PIXEL_MAX_VALUE = 10,
    parameter int PIXEL_BITS      = $clog2(PIXEL_MAX_VALUE)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IMG_WR_EN,
    input  logic [IMAGE_SIZE_BITS:0] IMG_WR_ADDR,
    input  logic [PIXEL_BITS:0]    IMG_WR_DATA,
    input  logic                   START,
    input  logic                   AERIN_CTRL_BUSY,
    output logic [IMAGE_SIZE_BITS:0] NEXT_INDEX,
    output logic                   FOUND_NEXT_INDEX,
    output logic                   SORTER_BUSY,
    output logic                   SORT_DONE
);

    localparam int IW = idx_width(IMAGE_SIZE_BITS);
    localparam int PW = pix_width(PIXEL_BITS);
    localparam logic [IW-1:0] END_TOKEN = IW'(end_token(IMAGE_SIZE));
    localparam logic [IW-1:0] IDX_LAST  = IW'(IMAGE_SIZE - 1);
    localparam logic [PW-1:0] V_MAX     = PW'(PIXEL_MAX_VALUE);
    localparam logic [PW-1:0] V_ONE     = PW'(1);

    sorter_state_t r_state;
    logic [PW-1:0] r_pix [IMAGE_SIZE];
    logic [PW-1:0] r_v;
    logic [IW-1:0] r_i;
    logic [IW-1:0] r_next_index;
    logic          r_found;
    logic          r_done;
    logic          r_last;
    logic          r_eoi;

    logic w_match;
    logic w_wrap;
    logic w_last;

    assign w_match = r_pix[r_i[IMAGE_SIZE_BITS-1:0]] == r_v;
    assign w_wrap  = r_i == IDX_LAST;
    // v never reaches 0 while scanning, so zero pixels can never match
    assign w_last  = w_wrap && r_v == V_ONE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= IDLE;
            r_pix        <= '{default: '0};
            r_v          <= V_MAX;
            r_i          <= '0;
            r_next_index <= '0;
            r_found      <= 1'b0;
            r_done       <= 1'b0;
            r_last       <= 1'b0;
            r_eoi        <= 1'b0;
        end else begin
            r_found <= 1'b0;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (IMG_WR_EN && IMG_WR_ADDR < END_TOKEN)
                        r_pix[IMG_WR_ADDR[IMAGE_SIZE_BITS-1:0]] <= IMG_WR_DATA > V_MAX ? V_MAX : IMG_WR_DATA;
                    if (START) begin
                        r_state <= SCAN;
                        r_v     <= V_MAX;
                        r_i     <= '0;
                        r_last  <= 1'b0;
                        r_eoi   <= 1'b0;
                    end
                end
                SCAN: begin
                    r_i    <= w_wrap ? '0 : r_i + 1'b1;
                    r_v    <= w_wrap ? r_v - 1'b1 : r_v;
                    // remembers that the match just emitted was the final scan position
                    r_last <= w_last;
                    if (w_match) begin
                        r_next_index <= r_i;
                        r_found      <= 1'b1;
                        r_state      <= WAIT_BUSY;
                    end else if (w_last) begin
                        r_state <= EOI;
                    end
                end
                WAIT_BUSY: if (AERIN_CTRL_BUSY) r_state <= WAIT_FREE;
                WAIT_FREE: begin
                    if (!AERIN_CTRL_BUSY) begin
                        r_state <= r_eoi ? DONE : r_last ? EOI : SCAN;
                        r_done  <= r_eoi;
                    end
                end
                EOI: begin
                    r_next_index <= END_TOKEN;
                    r_found      <= 1'b1;
                    r_eoi        <= 1'b1;
                    r_state      <= WAIT_BUSY;
                end
                DONE: begin
                    r_state <= IDLE;
                    r_v     <= V_MAX;
                    r_i     <= '0;
                    r_eoi   <= 1'b0;
                    r_last  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign NEXT_INDEX       = r_next_index;
    assign FOUND_NEXT_INDEX = r_found;
    assign SORT_DONE        = r_done;
    assign SORTER_BUSY      = r_state != IDLE;

endmodule

// File: tb/tb_image_sorter.sv
// tb_image_sorter: directed table-driven bench for image_sorter with an AER responder model
module tb_image_sorter;

    logic       CLK = 1'b0;
    logic       RST;
    logic       IMG_WR_EN;
    logic [3:0] IMG_WR_ADDR;
    logic [4:0] IMG_WR_DATA;
    logic       START;
    logic       AERIN_CTRL_BUSY;
    logic [3:0] NEXT_INDEX;
    logic       FOUND_NEXT_INDEX;
    logic       SORTER_BUSY;
    logic       SORT_DONE;

    int errors = 0;
    int checks = 0;
    int rise = 2;
    int hold = 4;

    typedef struct {
        string           name;
        logic [0:4][4:0] pix;
        logic [0:5][3:0] exp;
        int              n;
        int              lat;
    } vec_t;

    vec_t vecs[5];

    image_sorter dut (
        .CLK(CLK),
        .RST(RST),
        .IMG_WR_EN(IMG_WR_EN),
        .IMG_WR_ADDR(IMG_WR_ADDR),
        .IMG_WR_DATA(IMG_WR_DATA),
        .START(START),
        .AERIN_CTRL_BUSY(AERIN_CTRL_BUSY),
        .NEXT_INDEX(NEXT_INDEX),
        .FOUND_NEXT_INDEX(FOUND_NEXT_INDEX),
        .SORTER_BUSY(SORTER_BUSY),
        .SORT_DONE(SORT_DONE)
    );

    always #5 CLK = ~CLK;

    // Responder: raises BUSY rise cycles after a FOUND pulse, holds it hold cycles
    initial begin
        int cnt;
        cnt = 0;
        AERIN_CTRL_BUSY = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (RST) begin
                cnt = 0;
                AERIN_CTRL_BUSY = 1'b0;
            end else if (cnt == 0) begin
                if (FOUND_NEXT_INDEX) cnt = 1;
            end else begin
                cnt++;
                if (cnt == rise + 1) AERIN_CTRL_BUSY = 1'b1;
                if (cnt == rise + hold + 1) begin
                    AERIN_CTRL_BUSY = 1'b0;
                    cnt = 0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic wr(input int addr, input int data);
        IMG_WR_EN = 1'b1;
        IMG_WR_ADDR = 4'(addr);
        IMG_WR_DATA = 5'(data);
        @(negedge CLK);
        IMG_WR_EN = 1'b0;
    endtask

    task automatic load(input logic [0:4][4:0] p);
        for (int i = 0; i < 5; i++) wr(i, int'(p[i]));
    endtask

    // Runs one pass from START to SORT_DONE and checks the emitted sequence.
    // With inject set, START and a write to pixel 0 are pulsed during WAIT_FREE
    // of the first emission; both must be ignored.
    task automatic run_pass(input string name, input logic [0:5][3:0] exp, input int n,
                            input int exp_lat, input bit inject);
        logic [3:0] got[$];
        int t;
        int last_t;
        int busy_seen;
        bit done;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        t = 0;
        last_t = 0;
        busy_seen = 0;
        done = 1'b0;
        while (!done && t < 3000) begin
            @(negedge CLK);
            t++;
            START = 1'b0;
            IMG_WR_EN = 1'b0;
            if (FOUND_NEXT_INDEX) begin
                check({name, " busy_at_found"}, 32'(AERIN_CTRL_BUSY), 0);
                check({name, " sorter_busy"}, 32'(SORTER_BUSY), 1);
                if (got.size() == 0) check({name, " latency"}, t, exp_lat);
                else begin
                    checks++;
                    if (t - last_t < rise + hold + 2) begin
                        errors++;
                        $display("FAIL %s gap: got %0d cycles expected at least %0d", name, t - last_t, rise + hold + 2);
                    end
                end
                got.push_back(NEXT_INDEX);
                last_t = t;
            end
            if (inject && got.size() == 1 && busy_seen < 3) begin
                if (AERIN_CTRL_BUSY) busy_seen++;
                if (busy_seen == 2) begin
                    START = 1'b1;
                    IMG_WR_EN = 1'b1;
                    IMG_WR_ADDR = 4'd0;
                    IMG_WR_DATA = 5'd0;
                    busy_seen = 3;
                end
            end
            if (SORT_DONE) done = 1'b1;
        end
        START = 1'b0;
        IMG_WR_EN = 1'b0;
        check({name, " done_seen"}, 32'(done), 1);
        check({name, " count"}, got.size(), n);
        for (int i = 0; i < n; i++)
            if (i < got.size()) check($sformatf("%s idx%0d", name, i), 32'(got[i]), 32'(exp[i]));
        @(negedge CLK);
        check({name, " done_pulse_len"}, 32'(SORT_DONE), 0);
        check({name, " idle_after"}, 32'(SORTER_BUSY), 0);
    endtask

    initial begin
        int nf;
        RST = 1'b1;
        IMG_WR_EN = 1'b0;
        IMG_WR_ADDR = '0;
        IMG_WR_DATA = '0;
        START = 1'b0;

        vecs[0].name = "mixed";    vecs[0].pix = {5'd3, 5'd0, 5'd7, 5'd7, 5'd1};
        vecs[0].exp = {4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 4'd0}; vecs[0].n = 5; vecs[0].lat = 18;
        vecs[1].name = "zero";     vecs[1].pix = {5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
        vecs[1].exp = {4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}; vecs[1].n = 1; vecs[1].lat = 51;
        vecs[2].name = "saturate"; vecs[2].pix = {5'd4, 5'd15, 5'd0, 5'd0, 5'd2};
        vecs[2].exp = {4'd1, 4'd0, 4'd4, 4'd5, 4'd0, 4'd0}; vecs[2].n = 4; vecs[2].lat = 2;
        vecs[3].name = "ones";     vecs[3].pix = {5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
        vecs[3].exp = {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5}; vecs[3].n = 6; vecs[3].lat = 46;
        vecs[4].name = "ties";     vecs[4].pix = {5'd10, 5'd9, 5'd10, 5'd0, 5'd31};
        vecs[4].exp = {4'd0, 4'd2, 4'd4, 4'd1, 4'd5, 4'd0}; vecs[4].n = 5; vecs[4].lat = 1;

        @(negedge CLK);
        @(negedge CLK);
        check("rst next_index", 32'(NEXT_INDEX), 0);
        check("rst found", 32'(FOUND_NEXT_INDEX), 0);
        check("rst busy", 32'(SORTER_BUSY), 0);
        check("rst done", 32'(SORT_DONE), 0);
        RST = 1'b0;
        @(negedge CLK);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            load(vecs[v].pix);
            run_pass(vecs[v].name, vecs[v].exp, vecs[v].n, vecs[v].lat, 1'b0);
        end

        // Out-of-range writes, including one that would alias pixel 0 if truncated
        do_reset();
        load({5'd0, 5'd0, 5'd0, 5'd0, 5'd6});
        wr(5, 9);
        wr(6, 9);
        wr(8, 9);
        run_pass("addr_range", {4'd4, 4'd5, 4'd0, 4'd0, 4'd0, 4'd0}, 2, 25, 1'b0);

        // START and write pulsed in WAIT_FREE, then a re-sort of the retained image
        do_reset();
        load({5'd3, 5'd0, 5'd7, 5'd7, 5'd1});
        run_pass("inject", {4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 4'd0}, 5, 18, 1'b1);
        run_pass("resort", {4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 4'd0}, 5, 18, 1'b0);

        // Slow responder: sorter must idle in WAIT_BUSY without extra pulses
        rise = 20;
        run_pass("slow_resp", {4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 4'd0}, 5, 18, 1'b0);
        rise = 2;

        // Reset in WAIT_BUSY right after the second emission
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        nf = 0;
        for (int t = 0; t < 300 && nf < 2; t++) begin
            @(negedge CLK);
            if (FOUND_NEXT_INDEX) nf++;
        end
        check("midrst reached_second", nf, 2);
        RST = 1'b1;
        #1;
        check("midrst next_index", 32'(NEXT_INDEX), 0);
        check("midrst found", 32'(FOUND_NEXT_INDEX), 0);
        check("midrst busy", 32'(SORTER_BUSY), 0);
        check("midrst done", 32'(SORT_DONE), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        run_pass("post_rst_cleared", {4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}, 1, 51, 1'b0);
        load({5'd3, 5'd0, 5'd7, 5'd7, 5'd1});
        run_pass("post_rst_reload", {4'd2, 4'd3, 4'd0, 4'd4, 4'd5, 4'd0}, 5, 18, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/image_sorter.md
IMAGE_SORTER -- requirements
Module: image_sorter

Interface
REQ-001 SHALL have parameter IMAGE_SIZE, default 5: number of pixels per image.
REQ-002 SHALL have parameter IMAGE_SIZE_BITS, default $clog2(IMAGE_SIZE): index width base.
REQ-003 SHALL have parameter PIXEL_MAX_VALUE, default 10: largest legal pixel value.
REQ-004 SHALL have parameter PIXEL_BITS, default $clog2(PIXEL_MAX_VALUE): pixel width base.
REQ-005 SHALL have port CLK  input  1  clock; all state changes on rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port IMG_WR_EN  input  1  pixel write strobe.
REQ-008 SHALL have port IMG_WR_ADDR  input  IMAGE_SIZE_BITS+1  pixel index to write.
REQ-009 SHALL have port IMG_WR_DATA  input  PIXEL_BITS+1  pixel value to write.
REQ-010 SHALL have port START  input  1  begin one sort pass.
REQ-011 SHALL have port AERIN_CTRL_BUSY  input  1  downstream AER output stage busy.
REQ-012 SHALL have port NEXT_INDEX  output  IMAGE_SIZE_BITS+1  emitted pixel index or end token.
REQ-013 SHALL have port FOUND_NEXT_INDEX  output  1  one-cycle valid pulse for NEXT_INDEX.
REQ-014 SHALL have port SORTER_BUSY  output  1  high whenever state is not IDLE.
REQ-015 SHALL have port SORT_DONE  output  1  one-cycle pulse when pass completes.

Function
REQ-016 SHALL hold IMAGE_SIZE pixel registers; write accepted only in IDLE with IMG_WR_ADDR < IMAGE_SIZE; otherwise ignored.
REQ-017 SHALL saturate written values above PIXEL_MAX_VALUE to PIXEL_MAX_VALUE.
REQ-018 SHALL implement states IDLE, SCAN, WAIT_BUSY, WAIT_FREE, EOI, DONE.
REQ-019 IDLE: START=1 -> SCAN with value counter v=PIXEL_MAX_VALUE, index counter i=0; START ignored in all other states.
REQ-020 SCAN: examine one pixel per cycle; pixel[i]==v -> register NEXT_INDEX=i, FOUND_NEXT_INDEX=1 for exactly one cycle, advance counters, go WAIT_BUSY; else advance counters, stay SCAN.
REQ-021 Counter advance: i<IMAGE_SIZE-1 -> i+1; else i=0, v-1; advancing past v=1, i=IMAGE_SIZE-1 -> EOI instead of SCAN.
REQ-022 Pixels of value 0 SHALL never be emitted; emission order: descending value, ties ascending index.
REQ-023 WAIT_BUSY: remain until AERIN_CTRL_BUSY=1, then WAIT_FREE; WAIT_FREE: remain until AERIN_CTRL_BUSY=0, then SCAN, or EOI if counters exhausted.
REQ-024 EOI: emit NEXT_INDEX=IMAGE_SIZE with FOUND_NEXT_INDEX one cycle, then WAIT_BUSY/WAIT_FREE handshake, then DONE.
REQ-025 DONE: SORT_DONE=1 one cycle, -> IDLE; pixel registers retained for re-sort.
REQ-026 Latency: START sampled at edge k, pixel 0 matching v=PIXEL_MAX_VALUE -> FOUND_NEXT_INDEX high in cycle after edge k+1.
REQ-027 FOUND_NEXT_INDEX SHALL never assert while AERIN_CTRL_BUSY=1 or in WAIT_BUSY/WAIT_FREE; NEXT_INDEX held stable until next emission.
REQ-028 All-zero image: only EOI token emitted, after IMAGE_SIZE*PIXEL_MAX_VALUE scan cycles.

Reset
REQ-029 RST=1 SHALL force IDLE, v=PIXEL_MAX_VALUE, i=0, all pixels 0, NEXT_INDEX=0, FOUND_NEXT_INDEX=0, SORTER_BUSY=0, SORT_DONE=0, asynchronously, including mid-pass.
REQ-030 After RST release, first START SHALL run a full pass with no residual handshake state.

Structure
REQ-031 State enum and derived width constants (index width, pixel width, end-token value) SHALL live in shared package snn_sorter_pkg.
REQ-032 Single flat module; no sub-module; counters and FSM in one clocked process plus next-state logic.

Verification
REQ-033 Image {3,0,7,7,1}, MAX=10, responder raising BUSY 2 cycles after FOUND, dropping 4 cycles later -> indices 2,3,0,4 then 5, then SORT_DONE.
REQ-034 All-zero image, START -> single token 5 after 50 scan cycles, SORT_DONE next handshake.
REQ-035 Write value 15 to index 1 -> treated as 10; index 1 emitted first; write to address 6 ignored.
REQ-036 START and IMG_WR_EN pulsed during WAIT_FREE -> no restart, pixel unchanged, emission sequence unaltered.
REQ-037 RST asserted in WAIT_BUSY after second emission -> all outputs 0 same cycle; new load+START produces full correct sequence.
REQ-038 Responder holds BUSY low 20 cycles after FOUND -> sorter stays WAIT_BUSY, no extra FOUND_NEXT_INDEX pulses.
